// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared FSM states, widths and control encodings for the hazard/stall controller
package pipe_ctrl_pkg;

  localparam int CNT_W  = 4;
  localparam int PERF_W = 32;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_hold;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN   = 5'b11000;
  localparam ctrl_t CTRL_STALL = 5'b00010;
  localparam ctrl_t CTRL_FLUSH = 5'b11110;
  localparam ctrl_t CTRL_HOLD  = 5'b00001;

  // A load into x0 never produces a value, so it can never create a hazard.
  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       rs2_used
  );
    return mem_read && (rd != 5'd0) && ((rd == rs1) || (rs2_used && (rd == rs2)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - pipeline-side hazard inputs and stall/flush control outputs
interface hazard_stall_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [4:0]        rs1_id;
  logic [4:0]        rs2_id;
  logic              rs2_used_id;
  logic [4:0]        rd_ex;
  logic              memRead_ex;
  logic              branch_taken_ex;
  logic              dmem_busy;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              pipe_hold;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_count;

  modport master (
    output rs1_id, rs2_id, rs2_used_id, rd_ex, memRead_ex, branch_taken_ex, dmem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, stall_cycles, flush_count
  );

  modport slave (
    input  rs1_id, rs2_id, rs2_used_id, rd_ex, memRead_ex, branch_taken_ex, dmem_busy,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, stall_cycles, flush_count
  );

endinterface

// File: rtl/hazard_stall_ctrl_perf_counter.sv
// rtl/hazard_stall_ctrl_perf_counter.sv - free-running wrapping event counter
module perf_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int W = PERF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / branch / dmem-busy stall and flush controller
// Optional perf counters enabled by macro HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  hazard_stall_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LOAD_LAT - 1);

  state_t           state, next_state;
  state_t           ret_state, next_ret;
  state_t           resume;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             load_use;
  ctrl_t            ctrl;

  assign load_use = load_use_hit(bus.memRead_ex, bus.rd_ex, bus.rs1_id, bus.rs2_id, bus.rs2_used_id);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      ret_state <= RUN;
      cnt       <= '0;
    end else begin
      state     <= next_state;
      ret_state <= next_ret;
      cnt       <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_ret   = ret_state;
    next_cnt   = cnt;
    ctrl       = CTRL_RUN;
    // When busy drops, act on this cycle as the state that was interrupted.
    resume     = (state == MEM_WAIT) ? ret_state : state;

    if (bus.dmem_busy) begin
      ctrl       = CTRL_HOLD;
      next_state = MEM_WAIT;
      if (state != MEM_WAIT) begin
        next_ret = state;
      end
    end else if (bus.branch_taken_ex) begin
      ctrl       = CTRL_FLUSH;
      next_state = RUN;
      next_ret   = RUN;
      next_cnt   = '0;
    end else if (resume == LOAD_STALL) begin
      ctrl     = CTRL_STALL;
      next_ret = RUN;
      if (cnt <= CNT_W'(1)) begin
        next_state = RUN;
        next_cnt   = '0;
      end else begin
        next_state = LOAD_STALL;
        next_cnt   = cnt - CNT_W'(1);
      end
    end else if (load_use) begin
      ctrl     = CTRL_STALL;
      next_ret = RUN;
      if (LOAD_LAT > 1) begin
        next_state = LOAD_STALL;
        next_cnt   = LAT_M1;
      end else begin
        next_state = RUN;
        next_cnt   = '0;
      end
    end else begin
      next_state = RUN;
      next_ret   = RUN;
    end

    // Reset must force the idle encoding immediately, independent of inputs.
    if (reset) begin
      ctrl = CTRL_RUN;
    end
  end

  assign bus.pc_write    = ctrl.pc_write;
  assign bus.ifid_write  = ctrl.ifid_write;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_bubble = ctrl.idex_bubble;
  assign bus.pipe_hold   = ctrl.pipe_hold;

  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] flush_q;

`ifdef HAZARD_PERF_CNT_EN
  perf_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~ctrl.pc_write),
    .count (stall_q)
  );

  perf_counter #(.W(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ctrl.ifid_flush),
    .count (flush_q)
  );
`else
  assign stall_q = '0;
  assign flush_q = '0;
`endif

  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed-vector bench for hazard_stall_ctrl (LOAD_LAT 1 and 3)
module tb_hazard_stall_ctrl;

  localparam logic [4:0] NORM  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00010;
  localparam logic [4:0] FLUSH = 5'b11110;
  localparam logic [4:0] HOLD  = 5'b00001;

`ifdef HAZARD_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if b1 ();
  hazard_stall_ctrl_if b3 ();

  hazard_stall_ctrl #(.LOAD_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  hazard_stall_ctrl #(.LOAD_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

  wire [4:0] c1 = {b1.pc_write, b1.ifid_write, b1.ifid_flush, b1.idex_bubble, b1.pipe_hold};
  wire [4:0] c3 = {b3.pc_write, b3.ifid_write, b3.ifid_flush, b3.idex_bubble, b3.pipe_hold};

  task automatic drive(input logic mem, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic used, input logic br, input logic busy);
    b1.memRead_ex = mem;  b1.rd_ex = rd;  b1.rs1_id = r1;  b1.rs2_id = r2;
    b1.rs2_used_id = used; b1.branch_taken_ex = br; b1.dmem_busy = busy;
    b3.memRead_ex = mem;  b3.rd_ex = rd;  b3.rs1_id = r1;  b3.rs2_id = r2;
    b3.rs2_used_id = used; b3.branch_taken_ex = br; b3.dmem_busy = busy;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 5, 5, 0, 0, 1, 1);
    #1;
    vecs++; if (c1 !== NORM) begin errs++; $display("FAIL reset_ctl1 got=%b exp=%b", c1, NORM); end
    vecs++; if (c3 !== NORM) begin errs++; $display("FAIL reset_ctl3 got=%b exp=%b", c3, NORM); end
    vecs++; if (b3.stall_cycles !== 32'd0) begin errs++; $display("FAIL reset_stall_cnt got=%0d exp=0", b3.stall_cycles); end
    vecs++; if (b3.flush_count !== 32'd0) begin errs++; $display("FAIL reset_flush_cnt got=%0d exp=0", b3.flush_count); end
    @(negedge clk);
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_load_use();
    drive(1, 5, 5, 0, 0, 0, 0);
    #1;
    vecs++; if (c1 !== STALL) begin errs++; $display("FAIL load_use_stall got=%b exp=%b", c1, STALL); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    vecs++; if (c1 !== NORM) begin errs++; $display("FAIL load_use_back_to_run got=%b exp=%b", c1, NORM); end
    vecs++; if (c3 !== STALL) begin errs++; $display("FAIL load_use_lat3_second got=%b exp=%b", c3, STALL); end
    idle(3);
  endtask

  task automatic test_rs2_gating();
    drive(1, 7, 3, 7, 0, 0, 0);
    #1;
    vecs++; if (c1 !== NORM) begin errs++; $display("FAIL rs2_unused got=%b exp=%b", c1, NORM); end
    drive(1, 7, 3, 7, 1, 0, 0);
    #1;
    vecs++; if (c1 !== STALL) begin errs++; $display("FAIL rs2_used got=%b exp=%b", c1, STALL); end
    @(negedge clk);
    idle(3);
  endtask

  task automatic test_x0();
    drive(1, 0, 0, 0, 1, 0, 0);
    #1;
    vecs++; if (c1 !== NORM) begin errs++; $display("FAIL x0_rd got=%b exp=%b", c1, NORM); end
    vecs++; if (c3 !== NORM) begin errs++; $display("FAIL x0_rd_lat3 got=%b exp=%b", c3, NORM); end
    drive(0, 5, 5, 5, 1, 0, 0);
    #1;
    vecs++; if (c1 !== NORM) begin errs++; $display("FAIL no_memread got=%b exp=%b", c1, NORM); end
    @(negedge clk);
    idle(1);
  endtask

  task automatic test_lat3();
    logic [4:0] exp_seq [4];
    exp_seq[0] = STALL; exp_seq[1] = STALL; exp_seq[2] = STALL; exp_seq[3] = NORM;
    drive(1, 9, 9, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      vecs++; if (c3 !== exp_seq[i]) begin errs++; $display("FAIL lat3_cycle%0d got=%b exp=%b", i, c3, exp_seq[i]); end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0);
    end
    idle(1);
  endtask

  task automatic test_branch_over_stall();
    logic [31:0] f0;
    f0 = b3.flush_count;
    drive(1, 5, 5, 0, 0, 0, 0);
    #1;
    vecs++; if (c3 !== STALL) begin errs++; $display("FAIL br_first_stall got=%b exp=%b", c3, STALL); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 0);
    #1;
    vecs++; if (c3 !== FLUSH) begin errs++; $display("FAIL br_flush_lat3 got=%b exp=%b", c3, FLUSH); end
    vecs++; if (c1 !== FLUSH) begin errs++; $display("FAIL br_flush_run got=%b exp=%b", c1, FLUSH); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    vecs++; if (c3 !== NORM) begin errs++; $display("FAIL br_after_run got=%b exp=%b", c3, NORM); end
    vecs++; if (b3.flush_count !== f0 + 32'(PERF)) begin errs++; $display("FAIL br_flush_count got=%0d exp=%0d", b3.flush_count, f0 + 32'(PERF)); end
    idle(2);
  endtask

  task automatic test_busy_during_stall();
    logic [31:0] s0;
    s0 = b3.stall_cycles;
    drive(1, 5, 5, 0, 0, 0, 0);
    #1;
    vecs++; if (c3 !== STALL) begin errs++; $display("FAIL busy_stall1 got=%b exp=%b", c3, STALL); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    vecs++; if (c3 !== STALL) begin errs++; $display("FAIL busy_stall2 got=%b exp=%b", c3, STALL); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      vecs++; if (c3 !== HOLD) begin errs++; $display("FAIL busy_hold%0d got=%b exp=%b", i, c3, HOLD); end
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    vecs++; if (c3 !== STALL) begin errs++; $display("FAIL busy_resume got=%b exp=%b", c3, STALL); end
    @(negedge clk);
    #1;
    vecs++; if (c3 !== NORM) begin errs++; $display("FAIL busy_done got=%b exp=%b", c3, NORM); end
    vecs++; if (b3.stall_cycles - s0 !== 32'(7 * PERF)) begin errs++; $display("FAIL busy_stall_count got=%0d exp=%0d", b3.stall_cycles - s0, 7 * PERF); end
    idle(1);
  endtask

  task automatic test_busy_priority();
    drive(1, 5, 5, 0, 0, 1, 1);
    for (int i = 0; i < 2; i++) begin
      #1;
      vecs++; if (c1 !== HOLD) begin errs++; $display("FAIL prio_hold%0d got=%b exp=%b", i, c1, HOLD); end
      @(negedge clk);
    end
    drive(1, 5, 5, 0, 0, 1, 0);
    #1;
    vecs++; if (c1 !== FLUSH) begin errs++; $display("FAIL prio_branch got=%b exp=%b", c1, FLUSH); end
    @(negedge clk);
    drive(1, 5, 5, 0, 0, 0, 1);
    #1;
    vecs++; if (c1 !== HOLD) begin errs++; $display("FAIL prio_hold_lu got=%b exp=%b", c1, HOLD); end
    @(negedge clk);
    drive(1, 5, 5, 0, 0, 0, 0);
    #1;
    vecs++; if (c1 !== STALL) begin errs++; $display("FAIL prio_lu_pending got=%b exp=%b", c1, STALL); end
    @(negedge clk);
    idle(4);
  endtask

  task automatic test_reset_mem_wait();
    drive(1, 5, 5, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    vecs++; if (c3 !== HOLD) begin errs++; $display("FAIL memwait_hold got=%b exp=%b", c3, HOLD); end
    reset = 1'b1;
    #1;
    vecs++; if (c3 !== NORM) begin errs++; $display("FAIL memwait_reset_ctl got=%b exp=%b", c3, NORM); end
    vecs++; if (b3.stall_cycles !== 32'd0) begin errs++; $display("FAIL memwait_reset_cnt got=%0d exp=0", b3.stall_cycles); end
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    vecs++; if (c3 !== NORM) begin errs++; $display("FAIL after_reset_run got=%b exp=%b", c3, NORM); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rs2_gating();
    test_x0();
    test_lat3();
    test_branch_over_stall();
    test_busy_during_stall();
    test_busy_priority();
    test_reset_mem_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter LOAD_LAT, default 1, meaning load-to-use stall cycles (legal range 1..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have port rs1_id  input  5  IF/ID.RegisterRs1.
REQ-005 SHALL have port rs2_id  input  5  IF/ID.RegisterRs2.
REQ-006 SHALL have port rs2_used_id  input  1  IF/ID instruction reads rs2.
REQ-007 SHALL have port rd_ex  input  5  ID/EX.RegisterRd.
REQ-008 SHALL have port memRead_ex  input  1  ID/EX.MemRead.
REQ-009 SHALL have port branch_taken_ex  input  1  EX-stage branch or jump resolved taken.
REQ-010 SHALL have port dmem_busy  input  1  data memory not ready this cycle.
REQ-011 SHALL have port pc_write  output  1  PC update enable.
REQ-012 SHALL have port ifid_write  output  1  IF/ID register enable.
REQ-013 SHALL have port ifid_flush  output  1  zero IF/ID instruction.
REQ-014 SHALL have port idex_bubble  output  1  zero ID/EX control bits.
REQ-015 SHALL have port pipe_hold  output  1  freeze ID/EX, EX/MEM and MEM/WB.
REQ-016 SHALL have port stall_cycles  output  32  count of stalled cycles.
REQ-017 SHALL have port flush_count  output  32  count of taken-branch flushes.

Function
REQ-018 SHALL implement FSM states RUN, LOAD_STALL and MEM_WAIT with a 4-bit remaining-cycle counter.
REQ-019 SHALL detect load-use as memRead_ex & rd_ex!=0 & (rd_ex==rs1_id | (rs2_used_id & rd_ex==rs2_id)), evaluated combinationally.
REQ-020 SHALL, in RUN with load-use and no branch or busy, drive pc_write=0, ifid_write=0 and idex_bubble=1 in the same cycle.
REQ-021 SHALL, when LOAD_LAT>1, enter LOAD_STALL with counter LOAD_LAT-1 and hold the same outputs until the counter reaches 0, then return to RUN.
REQ-022 SHALL, on branch_taken_ex with dmem_busy=0 in any state, drive ifid_flush=1, idex_bubble=1 and pc_write=1, abort any LOAD_STALL, and go to RUN.
REQ-023 SHALL, while dmem_busy=1, drive pc_write=0, ifid_write=0 and pipe_hold=1 with no flush or bubble; branch and load-use remain pending and are re-evaluated when busy drops.
REQ-024 SHALL enter MEM_WAIT on dmem_busy rising, keep a LOAD_STALL counter frozen while in it, and resume the prior state when busy falls.
REQ-025 SHALL apply priority dmem_busy > branch_taken_ex > load-use.
REQ-026 SHALL, in RUN with no hazard, drive pc_write=1, ifid_write=1 and all other control outputs 0.
REQ-027 SHALL treat rd_ex==0 as never hazardous.

Reset
REQ-028 SHALL, on reset assertion at any time, enter RUN with counter 0 and both perf counters 0.
REQ-029 SHALL, with reset asserted, drive pc_write=1, ifid_write=1 and ifid_flush, idex_bubble and pipe_hold 0.

Configuration
REQ-030 SHALL, with HAZARD_PERF_CNT_EN defined, increment stall_cycles on every cycle with pc_write=0 and flush_count on every cycle with ifid_flush=1, both wrapping at 2^32.
REQ-031 SHALL, without HAZARD_PERF_CNT_EN, tie stall_cycles and flush_count to 0 and synthesise no counter flops.

Structure
REQ-032 SHALL place the FSM state enum and the counter width constant in shared package pipe_ctrl_pkg.
REQ-033 SHALL implement the optional counters as sub-module perf_counter, instantiated twice.

Verification
REQ-034 SHALL cover load-use: memRead_ex=1, rd_ex=5, rs1_id=5, LOAD_LAT=1 -> one cycle with pc_write=0, idex_bubble=1, then RUN.
REQ-035 SHALL cover rs2 gating: rd_ex=7, rs2_id=7, rs2_used_id=0 -> no stall; with rs2_used_id=1 -> stall.
REQ-036 SHALL cover x0: memRead_ex=1, rd_ex=0, rs1_id=0 -> no stall.
REQ-037 SHALL cover branch over stall: LOAD_LAT=3, branch_taken_ex=1 in the 2nd stall cycle -> ifid_flush=1 that cycle, then RUN with pc_write=1.
REQ-038 SHALL cover busy: dmem_busy=1 for 4 cycles during LOAD_STALL (LOAD_LAT=3) -> pipe_hold=1 for 4 cycles, the stall counter resumes afterwards, and stall_cycles grows by 4+3 with HAZARD_PERF_CNT_EN defined.
REQ-039 SHALL cover reset: reset asserted in MEM_WAIT -> outputs at reset values immediately, before the next clk edge.
